// File: rtl/coherence_pkg.sv
// rtl/coherence_pkg.sv - shared coherence codes for the bus arbiter and cache controllers
package coherence_pkg;

  // Bus message carried with each request and broadcast to the snoopers
  typedef enum logic [1:0] {
    MSG_EMPTY      = 2'b00,
    MSG_READ_MISS  = 2'b01,
    MSG_INVALIDATE = 2'b10,
    MSG_WRITE_MISS = 2'b11
  } bus_msg_e;

  // MSI line state held by each cache controller
  typedef enum logic [1:0] {
    MSI_INVALID  = 2'b00,
    MSI_SHARED   = 2'b01,
    MSI_MODIFIED = 2'b10
  } msi_state_e;

  // Processor-side operation presented to a cache controller
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } proc_op_e;

  // Arbiter transaction sequence
  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_BCAST = 3'd1,
    ARB_SNOOP = 3'd2,
    ARB_WB    = 3'd3,
    ARB_DONE  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin select starting just after the pointer
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_mask,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  // Scan from the farthest candidate back to ptr+1 so the nearest eligible one is kept
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (i_mask[SEL_W'((int'(i_ptr) + k) % N)]) begin
        o_any    = 1'b1;
        o_idx    = IDX_W'((int'(i_ptr) + k) % N);
        o_onehot = '0;
        o_onehot[SEL_W'((int'(i_ptr) + k) % N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// rtl/coherence_bus_arbiter.sv - round-robin snooping bus arbiter with ack collection and write-back
module coherence_bus_arbiter
  import coherence_pkg::*;
#(
  parameter int NUM_CPU = 4,
  parameter int ADDR_W  = 8,
  parameter int SRC_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                      i_clock,
  input  logic                      i_resetn,
  input  logic [NUM_CPU-1:0]        i_req,
  input  logic [2*NUM_CPU-1:0]      i_req_msg,
  input  logic [ADDR_W*NUM_CPU-1:0] i_req_addr,
  output logic [NUM_CPU-1:0]        o_grant,
  output logic                      o_bus_valid,
  output logic [1:0]                o_bus_msg,
  output logic [ADDR_W-1:0]         o_bus_addr,
  output logic [SRC_W-1:0]          o_bus_src,
  input  logic [NUM_CPU-1:0]        i_snoop_ack,
  input  logic [NUM_CPU-1:0]        i_snoop_wb,
  input  logic                      i_wb_done,
  output logic [NUM_CPU-1:0]        o_done,
  output logic                      o_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  arb_state_e          r_state;
  arb_state_e          w_state_next;
  logic [NUM_CPU-1:0]  r_grant;
  logic [1:0]          r_bus_msg;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [SRC_W-1:0]    r_bus_src;
  logic [SRC_W-1:0]    r_ptr;
  logic [NUM_CPU-1:0]  r_ack_mask;
  logic                r_wb;
  logic [TMR_W-1:0]    r_timer;
  logic                r_timeout;

  logic [NUM_CPU-1:0]  w_elig;
  logic [NUM_CPU-1:0]  w_pick_onehot;
  logic [SRC_W-1:0]    w_pick_idx;
  logic                w_pick_any;
  logic [1:0]          w_pick_msg;
  logic [ADDR_W-1:0]   w_pick_addr;
  logic [NUM_CPU-1:0]  w_src_onehot;
  logic [NUM_CPU-1:0]  w_req_mask;
  logic [NUM_CPU-1:0]  w_ack_seen;
  logic                w_ack_all;
  logic                w_wb_seen;
  logic [TMR_W-1:0]    w_timer_inc;
  logic                w_timed_out;

  // A request with an empty message is not a real bus request
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      w_elig[i] = i_req[i] && (i_req_msg[2*i +: 2] != MSG_EMPTY);
    end
  end

  rr_picker #(
    .N     (NUM_CPU),
    .IDX_W (SRC_W)
  ) u_rr_picker (
    .i_mask   (w_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // Route the winner's message and address to the latch inputs
  always_comb begin
    w_pick_msg  = '0;
    w_pick_addr = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      if (w_pick_onehot[i]) begin
        w_pick_msg  = i_req_msg[2*i +: 2];
        w_pick_addr = i_req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // Decode the current owner; its own ack/wb lines are never required
  always_comb begin
    w_src_onehot = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      w_src_onehot[i] = (r_bus_src == SRC_W'(i));
    end
  end

  assign w_req_mask  = ~w_src_onehot;
  assign w_ack_seen  = (r_ack_mask | i_snoop_ack) & w_req_mask;
  assign w_ack_all   = (w_ack_seen == w_req_mask);
  assign w_wb_seen   = r_wb | (|(i_snoop_ack & i_snoop_wb & w_req_mask));
  assign w_timer_inc = r_timer + TMR_W'(1);
  assign w_timed_out = !w_ack_all && (w_timer_inc >= TMR_W'(TIMEOUT));

  // State register
  always_ff @(posedge i_clock) begin
    if (!i_resetn) r_state <= ARB_IDLE;
    else           r_state <= w_state_next;
  end

  // Next-state sequencing; acks completing in the same cycle beat the timeout
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE:  if (w_pick_any) w_state_next = ARB_BCAST;
      ARB_BCAST: w_state_next = ARB_SNOOP;
      ARB_SNOOP: begin
        if (w_ack_all)        w_state_next = w_wb_seen ? ARB_WB : ARB_DONE;
        else if (w_timed_out) w_state_next = ARB_DONE;
      end
      ARB_WB:    if (i_wb_done) w_state_next = ARB_DONE;
      ARB_DONE:  w_state_next = ARB_IDLE;
      default:   w_state_next = ARB_IDLE;
    endcase
  end

  // Owner latches, round-robin pointer and snoop bookkeeping
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_grant    <= '0;
      r_bus_msg  <= '0;
      r_bus_addr <= '0;
      r_bus_src  <= '0;
      r_ptr      <= SRC_W'(NUM_CPU - 1);
      r_ack_mask <= '0;
      r_wb       <= 1'b0;
      r_timer    <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_any) begin
            r_grant    <= w_pick_onehot;
            r_bus_src  <= w_pick_idx;
            r_bus_msg  <= w_pick_msg;
            r_bus_addr <= w_pick_addr;
          end
        end
        ARB_BCAST: begin
          r_ack_mask <= '0;
          r_wb       <= 1'b0;
          r_timer    <= '0;
          r_timeout  <= 1'b0;
        end
        ARB_SNOOP: begin
          r_ack_mask <= r_ack_mask | i_snoop_ack;
          r_wb       <= w_wb_seen;
          r_timer    <= w_timer_inc;
          if (w_timed_out) r_timeout <= 1'b1;
        end
        ARB_DONE: begin
          r_grant <= '0;
          r_ptr   <= r_bus_src;
        end
        default: ;
      endcase
    end
  end

  assign o_grant     = r_grant;
  assign o_bus_msg   = r_bus_msg;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_src   = r_bus_src;
  assign o_bus_valid = (r_state == ARB_BCAST);
  assign o_done      = (r_state == ARB_DONE) ? w_src_onehot : '0;
  assign o_err       = (r_state == ARB_DONE) && r_timeout;

endmodule
